md5_pad: RTL and testbench

- Upstream feeder for md5_ctl.
- Accepts a message as a byte stream and accumulates it into a 16-word block buffer.
- Applies MD5 padding: a 0x80 byte, zero fill, then the 64-bit little-endian bit length.
- Bursts each 512-bit block into md5_ctl as 16 consecutive word strobes, honouring md5_ctl busy, and pulses md5_ctl reset at the start of every new message.

---
 rtl/md5_pad_pkg.sv | 15 +
 rtl/md5_blkbuf.sv | 26 ++
 rtl/md5_pad.sv | 132 +++++++++++++
 tb/tb_md5_pad.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/md5_pad_pkg.sv
// md5_pad_pkg: FSM encoding, block constants and the byte-to-word packing helper
package md5_pad_pkg;
  typedef enum logic [2:0] {IDLE, FILL, PAD_80, PAD_Z, LEN, SEND, DRAIN} state_t;
  localparam int BLOCK_BYTES = 64;
  localparam int LEN_OFS = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  typedef struct packed {
    logic [3:0] word;
    logic [4:0] ofs;
  } pos_t;
  // ofs counts from the word MSB, so byte 0 of a word is its top byte
  function automatic pos_t pack_pos(input logic [5:0] idx);
    return '{word: idx[5:2], ofs: {idx[1:0], 3'b000}};
  endfunction
endpackage

// File: rtl/md5_blkbuf.sv
// md5_blkbuf: 16x32 block buffer, byte write port, word read port, clear
module md5_blkbuf
  import md5_pad_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        we,
  input  logic [5:0]  idx,
  input  logic [7:0]  data,
  input  logic [3:0]  word,
  output logic [31:0] rdata
);
  logic [31:0] mem_q [16];
  logic [31:0] mem_d [16];
  pos_t p;
  logic [4:0] msb;
  always_comb begin
    p = pack_pos(idx);
    msb = 5'd31 - p.ofs;
    mem_d = mem_q;
    if (clr) for (int i = 0; i < 16; i++) mem_d[i] = '0;
    if (we) mem_d[p.word][msb -: 8] = data;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rdata = mem_q[word];
endmodule

// File: rtl/md5_pad.sv
// md5_pad: byte-stream MD5 padder feeding md5_ctl with 16-word block bursts
module md5_pad
  import md5_pad_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [0:7]  in_data,
  input  logic        in_end,
  output logic        in_ready,
  output logic        ctl_rst_o,
  output logic        ctl_rdy_o,
  output logic [0:31] ctl_msg_o,
  input  logic        ctl_busy_i,
  output logic        pad_busy
);
  state_t state_q, state_d, ret_q, ret_d;
  logic [6:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic last_q, last_d, burst_q, burst_d, seen_q, seen_d, rdy_q, rdy_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [1:0] to_q, to_d;
  logic [31:0] msg_q, msg_d, rdata;
  logic take, byte_acc, we, full;
  logic [7:0] wdata;
  assign full = idx_q == 7'(BLOCK_BYTES);
  assign ctl_rdy_o = rdy_q;
  assign ctl_msg_o = msg_q;
  md5_blkbuf u_buf (
    .clk(clk), .clr(rst || ctl_rst_o), .we(we), .idx(idx_q[5:0]),
    .data(wdata), .word(wcnt_q), .rdata(rdata)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      ret_q <= FILL;
      idx_q <= '0;
      len_q <= '0;
      last_q <= 1'b0;
      burst_q <= 1'b0;
      seen_q <= 1'b0;
      to_q <= '0;
      wcnt_q <= '0;
      rdy_q <= 1'b0;
      msg_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      idx_q <= idx_d;
      len_q <= len_d;
      last_q <= last_d;
      burst_q <= burst_d;
      seen_q <= seen_d;
      to_q <= to_d;
      wcnt_q <= wcnt_d;
      rdy_q <= rdy_d;
      msg_q <= msg_d;
    end
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    idx_d = we ? idx_q + 7'd1 : idx_q;
    len_d = byte_acc ? len_q + LEN_W'(8) : len_q;
    last_d = last_q;
    burst_d = burst_q;
    seen_d = seen_q;
    to_d = to_q;
    wcnt_d = wcnt_q;
    rdy_d = 1'b0;
    msg_d = '0;
    case (state_q)
      IDLE: if (take) begin
        state_d = in_end ? PAD_80 : FILL;
        len_d = byte_acc ? LEN_W'(8) : '0;
        last_d = 1'b0;
      end
      FILL: if (take && in_end) state_d = PAD_80;
        else if (byte_acc && idx_q == 7'(BLOCK_BYTES - 1)) begin
          state_d = SEND;
          ret_d = FILL;
        end
      PAD_80: begin
        state_d = full ? SEND : PAD_Z;
        ret_d = PAD_80;
      end
      PAD_Z: if (idx_q == 7'(LEN_OFS)) state_d = LEN;
        else if (full) begin
          state_d = SEND;
          ret_d = PAD_Z;
        end
      LEN: if (idx_q == 7'(BLOCK_BYTES - 1)) begin
        state_d = SEND;
        last_d = 1'b1;
      end
      SEND: if (burst_q) begin
        rdy_d = 1'b1;
        msg_d = rdata;
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == 4'd15) begin
          burst_d = 1'b0;
          state_d = DRAIN;
        end
      end else if (!ctl_busy_i) burst_d = 1'b1;
      DRAIN: begin
        seen_d = seen_q | ctl_busy_i;
        to_d = to_q + 2'd1;
        // wait for md5_ctl to take the block, or give up if busy never rises
        if (!ctl_busy_i && (seen_q || to_q == 2'd3)) begin
          state_d = last_q ? IDLE : ret_q;
          idx_d = '0;
          seen_d = 1'b0;
          to_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = !rst && (state_q == IDLE || (state_q == FILL && !full));
    byte_acc = in_ready && in_valid;
    take = in_ready && (in_valid || in_end);
    ctl_rst_o = take && state_q == IDLE;
    pad_busy = !rst && state_q != IDLE;
    we = !rst && (byte_acc || state_q == LEN || (state_q == PAD_80 && !full) ||
         (state_q == PAD_Z && !full && idx_q != 7'(LEN_OFS)));
    wdata = state_q == PAD_80 ? PAD_BYTE :
            state_q == LEN    ? len_q[{idx_q[2:0], 3'b000} +: 8] :
            state_q == PAD_Z  ? 8'h00 : in_data;
  end
endmodule

// File: tb/tb_md5_pad.sv
// tb_md5_pad: directed-vector bench for the MD5 byte padder
module tb_md5_pad;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_end = 1'b0, ctl_busy_i = 1'b0;
  logic [0:7] in_data = '0;
  logic in_ready, ctl_rst_o, ctl_rdy_o, pad_busy;
  logic [0:31] ctl_msg_o;
  int vectors = 0, miscompares = 0, rst_pulses = 0, overlap = 0;
  logic [31:0] words[$];
  logic [31:0] exp_w[$];

  always #5 clk = ~clk;

  md5_pad dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_end(in_end),
    .in_ready(in_ready), .ctl_rst_o(ctl_rst_o), .ctl_rdy_o(ctl_rdy_o),
    .ctl_msg_o(ctl_msg_o), .ctl_busy_i(ctl_busy_i), .pad_busy(pad_busy)
  );

  always begin
    @(negedge clk);
    #2;
    if (ctl_rdy_o) words.push_back(ctl_msg_o);
    if (ctl_rst_o) rst_pulses++;
    if (ctl_rdy_o && in_ready) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic v, input logic e);
    int t = 0;
    in_valid = v;
    in_data = d;
    in_end = e;
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_end = 1'b0;
  endtask

  task automatic send_msg(input int n);
    if (n == 0) push(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) push(8'h61, 1'b1, i == n - 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (pad_busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", t < 3000, 1);
  endtask

  task automatic start(input int n);
    words.delete();
    exp_w.delete();
    rst_pulses = 0;
    for (int i = 0; i < n; i++) exp_w.push_back('0);
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, words.size(), exp_w.size());
    foreach (exp_w[i])
      chk($sformatf("%s_w%0d", tag, i), (i < words.size()) ? {32'h0, words[i]} : 64'hx, exp_w[i]);
    chk({tag, "_ctl_rst"}, rst_pulses, 1);
  endtask

  initial begin
    int n, t;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rdy", ctl_rdy_o, 0);
    chk("rst_pad_busy", pad_busy, 0);
    chk("rst_ctl_rst", ctl_rst_o, 0);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", in_ready, 1);

    start(16);
    exp_w[0] = 32'h61616161;
    exp_w[1] = 32'h80000000;
    exp_w[14] = 32'h20000000;
    send_msg(4);
    wait_idle();
    check_words("aaaa");

    start(16);
    exp_w[0] = 32'h80000000;
    send_msg(0);
    wait_idle();
    check_words("empty");

    start(16);
    for (int i = 0; i < 13; i++) exp_w[i] = 32'h61616161;
    exp_w[13] = 32'h61616180;
    exp_w[14] = 32'hB8010000;
    send_msg(55);
    wait_idle();
    check_words("len55");

    start(32);
    for (int i = 0; i < 14; i++) exp_w[i] = 32'h61616161;
    exp_w[14] = 32'h80000000;
    exp_w[30] = 32'hC0010000;
    send_msg(56);
    wait_idle();
    check_words("len56");

    start(32);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h61616161;
    exp_w[16] = 32'h80000000;
    exp_w[30] = 32'h00020000;
    send_msg(64);
    wait_idle();
    check_words("len64");
    chk("in_ready_during_send", overlap, 0);

    start(0);
    ctl_busy_i = 1'b1;
    send_msg(4);
    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (ctl_rdy_o) n++;
    end
    chk("busy_hold_no_rdy", n, 0);
    chk("busy_hold_pad_busy", pad_busy, 1);
    ctl_busy_i = 1'b0;
    n = 0;
    t = 0;
    while (n < 8 && t < 100) begin
      @(negedge clk);
      t++;
      if (ctl_rdy_o) n++;
    end
    chk("burst_w7_reached", n, 8);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdy", ctl_rdy_o, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    rst = 1'b0;
    #1 chk("rst_mid_in_ready_after", in_ready, 1);
    @(negedge clk);
    chk("rst_mid_words", words.size(), 8);

    start(16);
    exp_w[0] = 32'h61616161;
    exp_w[1] = 32'h80000000;
    exp_w[14] = 32'h20000000;
    send_msg(4);
    wait_idle();
    check_words("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
